// File: rtl/filter_config_sequencer_if.sv
// Host register bus between the Avalon-side master and the filter configuration sequencer.
// Writes are single-cycle strobes; reads return registered data one clock later.
interface filter_config_sequencer_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/filter_config_sequencer.sv
// Shadow/active configuration bank for the image filter pipe: the host fills the shadow bank,
// commits, and the bank is applied atomically at a frame boundary, followed by a pipe flush window.
module filter_config_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter logic [9:0]  APPLY_V_LINE = 10'd2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  filter_config_sequencer_if.slave    host,
  input  logic                        master_enable,
  input  logic [10:0]                 H_Count,
  input  logic [9:0]                  V_Count,
  output logic                        pipe_enable,
  output logic [2:0]                  filter_mode,
  output logic [71:0]                 coef_out,
  output logic                        scale_out,
  output logic                        busy,
  output logic [15:0]                 apply_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, FLUSH = 2'd2, RUN = 2'd3} state_t;

  localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [15:0]        flush_cnt_q;
  logic [2:0]         shadow_mode;
  logic signed [7:0]  shadow_coef [9];
  logic               shadow_scale;
  logic [71:0]        shadow_packed;
  logic               commit, boundary, apply, flush_done, pipe_enable_d;
  logic [31:0]        rd_value;
  logic               unused_wr_bits;

  // Modes 6 and 7 are undefined in the pipe; they go live as pass-through.
  function automatic logic [2:0] commit_mode(input logic [2:0] m);
    return (m > 3'd5) ? 3'd0 : m;
  endfunction

  assign unused_wr_bits = &{1'b0, host.wr_data[31:8]};
  assign commit     = host.wr_en && (host.wr_addr == 4'd11);
  assign boundary   = (V_Count == APPLY_V_LINE) && (H_Count == 11'd0);
  assign flush_done = (flush_cnt_q == 16'd0);
  assign busy       = (state_q == PENDING) || (state_q == FLUSH);

  always_comb begin
    shadow_packed = '0;
    for (int i = 0; i < 9; i++) shadow_packed[71 - 8*i -: 8] = shadow_coef[i];
  end

  // State register and flush counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (apply)
        flush_cnt_q <= FLUSH_LOAD;
      else if (state_q == FLUSH && !flush_done)
        flush_cnt_q <= flush_cnt_q - 16'd1;
    end
  end

  // Next-state logic; a commit only arms PENDING, so a boundary in the same cycle is not used
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit) state_d = PENDING;
               else if (master_enable) state_d = RUN;
      RUN:     if (commit) state_d = PENDING;
      PENDING: if (apply) state_d = FLUSH;
      FLUSH:   if (flush_done) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    apply         = (state_q == PENDING) && (!master_enable || boundary);
    pipe_enable_d = 1'b0;
    unique case (state_d)
      RUN:     pipe_enable_d = master_enable;
      PENDING: pipe_enable_d = pipe_enable;
      default: pipe_enable_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadow_mode  <= 3'd0;
      shadow_scale <= 1'b1;
      for (int i = 0; i < 9; i++) shadow_coef[i] <= (i == 4) ? 8'sd16 : 8'sd0;
    end else if (host.wr_en) begin
      case (host.wr_addr)
        4'd0:                        shadow_mode <= host.wr_data[2:0];
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8, 4'd9:      shadow_coef[host.wr_addr - 4'd1] <= host.wr_data[7:0];
        4'd10:                       shadow_scale <= host.wr_data[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pipe_enable <= 1'b0;
      filter_mode <= 3'd0;
      coef_out    <= 72'h00_0000_0010_0000_0000;
      scale_out   <= 1'b1;
      apply_count <= 16'd0;
    end else begin
      pipe_enable <= pipe_enable_d;
      if (apply) begin
        filter_mode <= commit_mode(shadow_mode);
        coef_out    <= shadow_packed;
        scale_out   <= shadow_scale;
        apply_count <= apply_count + 16'd1;
      end
    end
  end

  always_comb begin
    rd_value = 32'd0;
    case (host.rd_addr)
      4'd0:                        rd_value = {29'd0, shadow_mode};
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9:      rd_value = {24'd0, shadow_coef[host.rd_addr - 4'd1]};
      4'd10:                       rd_value = {31'd0, shadow_scale};
      4'd12:                       rd_value = {29'd0, busy, state_q};
      4'd13:                       rd_value = {16'd0, apply_count};
      default:                     rd_value = 32'd0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) host.rd_data <= 32'd0;
    else       host.rd_data <= rd_value;
  end

endmodule

// File: tb/tb_filter_config_sequencer.sv
// Directed bench for filter_config_sequencer: reset state, boundary-timed apply, flush window,
// ignored commits, mode sanitising and reset during flush.
module tb_filter_config_sequencer;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        master_enable;
  logic [10:0] H_Count;
  logic [9:0]  V_Count;
  logic        pipe_enable;
  logic [2:0]  filter_mode;
  logic [71:0] coef_out;
  logic        scale_out;
  logic        busy;
  logic [15:0] apply_count;

  int tests = 0;
  int fails = 0;

  localparam logic [71:0] COEF_RST = 72'h00_0000_0010_0000_0000;
  localparam logic [71:0] COEF_A   = 72'h01_FE03_FC64_FA07_F809;

  filter_config_sequencer_if host ();

  filter_config_sequencer #(.FLUSH_CYCLES(16), .APPLY_V_LINE(10'd2)) dut (
    .Clock(Clock), .Reset(Reset), .host(host), .master_enable(master_enable),
    .H_Count(H_Count), .V_Count(V_Count), .pipe_enable(pipe_enable),
    .filter_mode(filter_mode), .coef_out(coef_out), .scale_out(scale_out),
    .busy(busy), .apply_count(apply_count)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    host.wr_en = 1'b1; host.wr_addr = a; host.wr_data = d;
    tick();
    host.wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    host.rd_addr = a;
    tick();
    check(tag, 72'(host.rd_data), 72'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pipe"},  72'(pipe_enable), 72'd0);
    check({tag, "_mode"},  72'(filter_mode), 72'd0);
    check({tag, "_coef"},  coef_out, COEF_RST);
    check({tag, "_scale"}, 72'(scale_out), 72'd1);
    check({tag, "_busy"},  72'(busy), 72'd0);
    check({tag, "_count"}, 72'(apply_count), 72'd0);
  endtask

  // Counts cycles until busy drops (bounded) and reports whether pipe_enable rose meanwhile.
  task automatic wait_flush(output int cycles, output logic saw_enable);
    cycles = 0;
    saw_enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      if (pipe_enable) saw_enable = 1'b1;
      tick();
      cycles++;
    end
  endtask

  initial begin
    int   low_cycles;
    int   n;
    logic saw;
    Reset = 1'b1; master_enable = 1'b0; H_Count = 11'd5; V_Count = 10'd0;
    host.wr_en = 1'b0; host.wr_addr = 4'd0; host.wr_data = 32'd0; host.rd_addr = 4'd0;
    tick(); tick();
    check_reset_outputs("rst");
    check("rst_rd_data", 72'(host.rd_data), 72'd0);
    Reset = 1'b0;

    rd_check("rd_mode_rst",   4'd0,  32'd0);
    rd_check("rd_c_m1m1_rst", 4'd1,  32'd0);
    rd_check("rd_c00_rst",    4'd5,  32'd16);
    rd_check("rd_c_p1p1_rst", 4'd9,  32'd0);
    rd_check("rd_scale_rst",  4'd10, 32'd1);
    rd_check("rd_status_rst", 4'd12, 32'd0);
    rd_check("rd_count_rst",  4'd13, 32'd0);
    rd_check("rd_unmapped",   4'd14, 32'd0);
    check("idle_pipe", 72'(pipe_enable), 72'd0);

    // Load shadow bank; active outputs must not move
    wr(4'd0, 32'd5);
    wr(4'd1, 32'h01); wr(4'd2, 32'hFE); wr(4'd3, 32'h03);
    wr(4'd4, 32'hFC); wr(4'd5, 32'h64); wr(4'd6, 32'hFA);
    wr(4'd7, 32'h07); wr(4'd8, 32'hF8); wr(4'd9, 32'h09);
    wr(4'd10, 32'd0);
    check("shadow_iso_mode", 72'(filter_mode), 72'd0);
    check("shadow_iso_coef", coef_out, COEF_RST);
    rd_check("rd_c_m1m0", 4'd2, 32'hFE);

    master_enable = 1'b1;
    tick();
    check("run_pipe_on", 72'(pipe_enable), 72'd1);
    check("run_busy", 72'(busy), 72'd0);
    rd_check("rd_status_run", 4'd12, 32'd3);

    wr(4'd11, 32'd0);
    check("pend_busy", 72'(busy), 72'd1);
    check("pend_pipe_hold", 72'(pipe_enable), 72'd1);
    check("pend_mode_old", 72'(filter_mode), 72'd0);
    wr(4'd11, 32'd0);
    V_Count = 10'd1; H_Count = 11'd0;
    tick();
    check("pend_v1_busy", 72'(busy), 72'd1);
    check("pend_v1_count", 72'(apply_count), 72'd0);
    V_Count = 10'd2; H_Count = 11'd7;
    tick();
    check("pend_v2h7_count", 72'(apply_count), 72'd0);

    H_Count = 11'd0;
    tick();
    H_Count = 11'd1;
    check("apply_mode", 72'(filter_mode), 72'd5);
    check("apply_coef", coef_out, COEF_A);
    check("apply_scale", 72'(scale_out), 72'd0);
    check("apply_count1", 72'(apply_count), 72'd1);
    check("apply_pipe_off", 72'(pipe_enable), 72'd0);
    check("apply_busy", 72'(busy), 72'd1);
    low_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pipe_enable) break;
      low_cycles++;
    end
    check("flush_len", 72'(low_cycles), 72'd16);
    check("flush_done_busy", 72'(busy), 72'd0);

    // A second boundary must not apply the ignored commit
    H_Count = 11'd0;
    tick();
    H_Count = 11'd1;
    tick();
    check("no_double_apply", 72'(apply_count), 72'd1);
    check("no_double_busy", 72'(busy), 72'd0);
    rd_check("rd_count1", 4'd13, 32'd1);

    master_enable = 1'b0;
    tick();
    check("me_fall_pipe", 72'(pipe_enable), 72'd0);
    rd_check("rd_status_run_me0", 4'd12, 32'd3);

    // Disabled pipe: apply the cycle after commit, ignoring V_Count
    V_Count = 10'd0; H_Count = 11'd7;
    wr(4'd0, 32'd2);
    wr(4'd11, 32'd0);
    check("me0_pend_busy", 72'(busy), 72'd1);
    check("me0_pend_mode", 72'(filter_mode), 72'd5);
    tick();
    check("me0_apply_mode", 72'(filter_mode), 72'd2);
    check("me0_apply_count", 72'(apply_count), 72'd2);
    wait_flush(n, saw);
    check("me0_flush_len", 72'(n), 72'd16);
    check("me0_flush_pipe", 72'(saw), 72'd0);
    check("me0_run_pipe", 72'(pipe_enable), 72'd0);
    rd_check("rd_status_me0", 4'd12, 32'd3);

    // Undefined mode goes live as pass-through but reads back as written
    wr(4'd0, 32'd7);
    wr(4'd11, 32'd0);
    tick();
    check("mode7_active", 72'(filter_mode), 72'd0);
    check("mode7_count", 72'(apply_count), 72'd3);
    rd_check("rd_mode7", 4'd0, 32'd7);
    wait_flush(n, saw);
    check("mode7_flush_len", 72'(n), 72'd15);

    // Commit coinciding with the boundary waits for the next match
    wr(4'd0, 32'd3);
    master_enable = 1'b1;
    tick();
    V_Count = 10'd2; H_Count = 11'd0;
    wr(4'd11, 32'd0);
    H_Count = 11'd1;
    check("coinc_busy", 72'(busy), 72'd1);
    check("coinc_count", 72'(apply_count), 72'd3);
    tick();
    check("coinc_wait_count", 72'(apply_count), 72'd3);
    check("coinc_wait_mode", 72'(filter_mode), 72'd0);
    H_Count = 11'd0;
    tick();
    H_Count = 11'd1;
    check("coinc_apply_count", 72'(apply_count), 72'd4);
    check("coinc_apply_mode", 72'(filter_mode), 72'd3);

    // Reset in the middle of the flush window
    tick(); tick(); tick();
    check("pre_rst_busy", 72'(busy), 72'd1);
    Reset = 1'b1;
    tick();
    master_enable = 1'b0;
    check_reset_outputs("rst_flush");
    check("rst_flush_rd", 72'(host.rd_data), 72'd0);
    Reset = 1'b0;
    rd_check("rst_flush_status", 4'd12, 32'd0);
    rd_check("rst_flush_shadow_mode", 4'd0, 32'd0);
    rd_check("rst_flush_shadow_c00", 4'd5, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
